// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// start/busy/done handshake; diff/bout change only on the edge that raises done.
module serial_subtractor #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e        state_q;
  logic [N-1:0]  a_sh_q, b_sh_q, r_sh_q;
  logic          br_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, bout_q;
  logic [N-1:0]  diff_q;

  logic          d_bit, br_d;
  logic [N:0]    r_ext;
  logic [N-1:0]  r_d;

  // Extended concatenation keeps the result shift legal when N == 1.
  always_comb begin
    d_bit = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    br_d  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    r_ext = {d_bit, r_sh_q};
    r_d   = r_ext[N:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          busy_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          br_q   <= br_d;
          r_sh_q <= r_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            diff_q  <= r_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at N=3, N=1 and N=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = '0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       bin_in = 1'b0;

  logic       busy3, done3, bout3;
  logic [2:0] diff3;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  int checks = 0;
  int errors = 0;
  logic [8:0] q3[$], q1[$], q8[$];
  logic [8:0] last_v[3] = '{default: '0};

  always #5 clk = ~clk;

  serial_subtractor #(.N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_in[2:0]), .b(b_in[2:0]),
    .bin(bin_in), .busy(busy3), .done(done3), .diff(diff3), .bout(bout3));
  serial_subtractor #(.N(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_in[0:0]), .b(b_in[0:0]),
    .bin(bin_in), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));
  serial_subtractor #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_in), .b(b_in),
    .bin(bin_in), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] res(input int sel);
    case (sel)
      0:       res = {5'b0, bout3, diff3};
      1:       res = {7'b0, bout1, diff1};
      default: res = {bout8, diff8};
    endcase
  endfunction

  function automatic logic [1:0] hs(input int sel);
    case (sel)
      0:       hs = {busy3, done3};
      1:       hs = {busy1, done1};
      default: hs = {busy8, done8};
    endcase
  endfunction

  function automatic logic [8:0] model(input int n, input logic [7:0] av, input logic [7:0] bv,
                                       input logic bi);
    int mask, d;
    mask = (1 << n) - 1;
    d = int'(av & mask[7:0]) - int'(bv & mask[7:0]) - int'(bi);
    model = 9'(((d < 0) ? (1 << n) : 0) | (d & mask));
  endfunction

  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) check_eq("done3_unexpected", 32'(done3), 32'd0);
      else check_eq("res3", 32'(res(0)), 32'(q3.pop_front()));
    end
    if (done1) begin
      if (q1.size() == 0) check_eq("done1_unexpected", 32'(done1), 32'd0);
      else check_eq("res1", 32'(res(1)), 32'(q1.pop_front()));
    end
    if (done8) begin
      if (q8.size() == 0) check_eq("done8_unexpected", 32'(done8), 32'd0);
      else check_eq("res8", 32'(res(2)), 32'(q8.pop_front()));
    end
  end

  // Called between edges; returns #1 after the done edge so a following call starts back-to-back.
  task automatic op(input int sel, input int n, input logic [7:0] av, input logic [7:0] bv,
                    input logic bi, input bit poke);
    logic [8:0] e;
    e = model(n, av, bv, bi);
    a_in = av; b_in = bv; bin_in = bi;
    start_v[sel] = 1'b1;
    case (sel)
      0: q3.push_back(e);
      1: q1.push_back(e);
      default: q8.push_back(e);
    endcase
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    a_in = 8'($urandom); b_in = 8'($urandom); bin_in = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      check_eq("run_hs", 32'(hs(sel)), 32'b10);
      check_eq("run_hold", 32'(res(sel)), 32'(last_v[sel]));
      if (poke && n > 1 && i == 0) start_v[sel] = 1'b1;
      if (i == 1) start_v[sel] = 1'b0;
      @(posedge clk); #1;
    end
    start_v[sel] = 1'b0;
    check_eq("done_hs", 32'(hs(sel)), 32'b01);
    last_v[sel] = e;
  endtask

  initial begin
    // Reset held low while start toggles: nothing may move.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start_v[0] = ~start_v[0];
      a_in = 8'($urandom); b_in = 8'($urandom);
      check_eq("rst_hold3", {busy3, done3, bout3, diff3}, 32'd0);
    end
    start_v[0] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_hs", 32'(hs(0)), 32'b00);

    op(0, 3, 8'd1, 8'd5, 1'b0, 1'b0);
    check_eq("basic_borrow", 32'(res(0)), 32'b1100);
    repeat (2) @(posedge clk);
    #1;
    op(0, 3, 8'd5, 8'd1, 1'b0, 1'b0);
    op(0, 3, 8'd7, 8'd7, 1'b0, 1'b0);
    repeat (1) @(posedge clk);
    #1;
    check_eq("idle_hs", 32'(hs(0)), 32'b00);
    op(0, 3, 8'd0, 8'd0, 1'b1, 1'b0);
    op(0, 3, 8'd7, 8'd0, 1'b1, 1'b0);
    op(0, 3, 8'd6, 8'd3, 1'b0, 1'b1);
    op(0, 3, 8'd3, 8'd1, 1'b0, 1'b0);
    check_eq("b2b_result", 32'(res(0)), 32'b0010);

    for (int av = 0; av < 8; av++)
      for (int bv = 0; bv < 8; bv++)
        for (int bi = 0; bi < 2; bi++)
          op(0, 3, 8'(av), 8'(bv), 1'(bi), (av == bv) ? 1'b1 : 1'b0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      op(1, 1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      if (i % 3 == 0) begin @(posedge clk); #1; end
    end
    for (int i = 0; i < 60; i++) begin
      op(2, 8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if (i % 4 == 0) begin @(posedge clk); #1; end
    end
    op(2, 8, 8'h00, 8'hFF, 1'b1, 1'b0);
    op(2, 8, 8'hFF, 8'hFE, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-RUN: outputs clear at once, abandoned operation never completes.
    a_in = 8'd2; b_in = 8'd5; bin_in = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_busy", 32'(busy3), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst3", {busy3, done3, bout3, diff3}, 32'd0);
    check_eq("async_rst8", {busy8, done8, bout8, diff8}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rst_low3", {busy3, done3, bout3, diff3}, 32'd0);
    end
    rst_n = 1'b1;
    last_v = '{default: '0};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("abandoned", {busy3, done3, bout3, diff3}, 32'd0);
    end
    op(0, 3, 8'd4, 8'd6, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    check_eq("q3_empty", 32'(q3.size()), 32'd0);
    check_eq("q1_empty", 32'(q1.size()), 32'd0);
    check_eq("q8_empty", 32'(q8.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
